if_segment_reg: RTL and testbench

Instruction-fetch stage register block for the pipelined CPU. Holds the program counter, produces `pc_plus4` (sr0 of the next-PC 2:1 mux) and consumes that mux's `res` as `npc`. It also latches the fetched instruction into the IF/ID segment register with stall, flush and valid tracking, and keeps a fetch counter for debug.

---
 rtl/if_segment_reg.sv | 77 +++++++
 tb/tb_if_segment_reg.sv | 113 +++++++++++
 2 files changed

// File: rtl/if_segment_reg.sv
// Fetch stage: program counter plus the IF/ID segment register, with
// stall/flush/valid tracking and a debug count of instructions accepted into ID.
module if_segment_reg #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] npc,
    input  logic [WIDTH-1:0] inst_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] pc_id,
    output logic [WIDTH-1:0] pc4_id,
    output logic [WIDTH-1:0] inst_id,
    output logic             valid_id,
    output logic [31:0]      fetch_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pc4;
        logic [WIDTH-1:0] inst;
        logic             valid;
    } id_slot_t;

    localparam id_slot_t BUBBLE = '{pc: '0, pc4: '0, inst: NOP, valid: 1'b0};

    logic     pc_en;
    logic     id_load;
    id_slot_t id_q;
    id_slot_t id_d;

    // A flush redirects fetch even while stalled: the held instruction is wrong-path.
    assign pc_en   = !stall || flush;
    assign id_load = !stall && !flush;

    assign pc_plus4 = pc + WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (pc_en)
            pc <= {npc[WIDTH-1:2], 2'b00};
    end

    always_comb begin
        id_d = id_q;
        if (flush)
            id_d = BUBBLE;
        else if (id_load)
            id_d = '{pc: pc, pc4: pc_plus4, inst: inst_in, valid: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            id_q <= BUBBLE;
        else
            id_q <= id_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            fetch_cnt <= '0;
        else if (id_load)
            fetch_cnt <= fetch_cnt + 32'd1;
    end

    assign pc_id    = id_q.pc;
    assign pc4_id   = id_q.pc4;
    assign inst_id  = id_q.inst;
    assign valid_id = id_q.valid;

endmodule

// File: tb/tb_if_segment_reg.sv
// Directed vector bench for if_segment_reg; instruction memory is modelled as
// inst = addr ^ 0x1234_0000 so expected ID contents can be computed by hand.
module tb_if_segment_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] npc, inst_in;
    logic [31:0] pc, pc_plus4, pc_id, pc4_id, inst_id, fetch_cnt;
    logic        valid_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign inst_in = pc ^ 32'h1234_0000;

    if_segment_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .npc(npc), .inst_in(inst_in),
        .pc(pc), .pc_plus4(pc_plus4), .pc_id(pc_id), .pc4_id(pc4_id),
        .inst_id(inst_id), .valid_id(valid_id), .fetch_cnt(fetch_cnt)
    );

    typedef struct {
        logic        rst, stall, flush;
        logic [31:0] npc;
        logic [31:0] e_pc, e_p4, e_pc_id, e_pc4_id, e_inst;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("pc",        idx, pc,        v.e_pc);
        chk("pc_plus4",  idx, pc_plus4,  v.e_p4);
        chk("pc_id",     idx, pc_id,     v.e_pc_id);
        chk("pc4_id",    idx, pc4_id,    v.e_pc4_id);
        chk("inst_id",   idx, inst_id,   v.e_inst);
        chk("valid_id",  idx, {31'd0, valid_id}, {31'd0, v.e_valid});
        chk("fetch_cnt", idx, fetch_cnt, v.e_cnt);
    endtask

    // Apply inputs away from the edge, clock once, sample just after the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] n);
        @(negedge clk);
        rst = r; stall = s; flush = f; npc = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //          rst  stl  fl   npc            pc             pc+4           pc_id          pc4_id         inst           v     cnt
        vecs[0]  = '{1'b1,1'b0,1'b0,32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 32'h0,         32'h0,         32'h0000_0013, 1'b0, 32'd0};
        vecs[1]  = '{1'b1,1'b0,1'b0,32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 32'h0,         32'h0,         32'h0000_0013, 1'b0, 32'd0};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0000_3004, 32'h0000_3004, 32'h0000_3008, 32'h0000_3000, 32'h0000_3004, 32'h1234_3000, 1'b1, 32'd1};
        vecs[3]  = '{1'b0,1'b0,1'b0,32'h0000_3008, 32'h0000_3008, 32'h0000_300C, 32'h0000_3004, 32'h0000_3008, 32'h1234_3004, 1'b1, 32'd2};
        vecs[4]  = '{1'b0,1'b1,1'b0,32'h0000_300C, 32'h0000_3008, 32'h0000_300C, 32'h0000_3004, 32'h0000_3008, 32'h1234_3004, 1'b1, 32'd2};
        vecs[5]  = '{1'b0,1'b1,1'b0,32'h0000_300C, 32'h0000_3008, 32'h0000_300C, 32'h0000_3004, 32'h0000_3008, 32'h1234_3004, 1'b1, 32'd2};
        vecs[6]  = '{1'b0,1'b0,1'b0,32'h0000_300C, 32'h0000_300C, 32'h0000_3010, 32'h0000_3008, 32'h0000_300C, 32'h1234_3008, 1'b1, 32'd3};
        vecs[7]  = '{1'b0,1'b0,1'b1,32'h0000_3100, 32'h0000_3100, 32'h0000_3104, 32'h0,         32'h0,         32'h0000_0013, 1'b0, 32'd3};
        vecs[8]  = '{1'b0,1'b0,1'b0,32'h0000_3104, 32'h0000_3104, 32'h0000_3108, 32'h0000_3100, 32'h0000_3104, 32'h1234_3100, 1'b1, 32'd4};
        vecs[9]  = '{1'b0,1'b1,1'b1,32'h0000_3200, 32'h0000_3200, 32'h0000_3204, 32'h0,         32'h0,         32'h0000_0013, 1'b0, 32'd4};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h0000_3007, 32'h0000_3004, 32'h0000_3008, 32'h0000_3200, 32'h0000_3204, 32'h1234_3200, 1'b1, 32'd5};
        vecs[11] = '{1'b0,1'b0,1'b0,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008, 32'h1234_3004, 1'b1, 32'd6};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0000, 32'hEDCB_FFFC, 1'b1, 32'd7};
        vecs[13] = '{1'b0,1'b1,1'b0,32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0000, 32'hEDCB_FFFC, 1'b1, 32'd7};
        vecs[14] = '{1'b1,1'b1,1'b1,32'h0000_0008, 32'h0000_3000, 32'h0000_3004, 32'h0,         32'h0,         32'h0000_0013, 1'b0, 32'd0};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; npc = '0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].npc);
            chk_all(i, vecs[i]);
        end

        // Free-run five fetches from reset, stall, then reset while stalled.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, pc_plus4);
        step(1'b0, 1'b1, 1'b0, pc_plus4);
        rv = '{1'b0,1'b1,1'b0,32'h0, 32'h0000_3014, 32'h0000_3018, 32'h0000_3010, 32'h0000_3014, 32'h1234_3010, 1'b1, 32'd5};
        chk_all(100, rv);

        step(1'b1, 1'b1, 1'b0, 32'h0000_4000);
        rv = '{1'b1,1'b1,1'b0,32'h0, 32'h0000_3000, 32'h0000_3004, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'd0};
        chk_all(101, rv);

        // First cycle out of reset is a bubble; RESET_PC's instruction lands one edge later.
        step(1'b0, 1'b0, 1'b0, 32'h0000_3004);
        rv = '{1'b0,1'b0,1'b0,32'h0, 32'h0000_3004, 32'h0000_3008, 32'h0000_3000, 32'h0000_3004, 32'h1234_3000, 1'b1, 32'd1};
        chk_all(102, rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
